dctm: RTL and testbench



---
 rtl/dctm_pkg.sv | 34 +++
 rtl/dctm_mul8x8.sv | 58 +++++
 rtl/dctm.sv | 60 ++++++
 tb/tb_dctm.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dctm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dctm_pkg
// Description : Shared widths, rounding/saturation constants and CSA helper
//               for the DCT coefficient multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package dctm_pkg;

    localparam int PIX_W     = 8;
    localparam int COEF_FRAC = 7;
    localparam int ROUND_K   = 64;
    localparam int SAT_MAX   = 255;

    typedef logic [PIX_W-1:0]   pix_t;
    typedef logic [PIX_W-1:0]   coef_t;
    typedef logic [2*PIX_W-1:0] prod_t;

    typedef struct packed {
        prod_t s;
        prod_t c;
    } csa_t;

    // Carry-out of the top bit is dropped: the true product always fits in
    // prod_t, so every intermediate sum is exact modulo 2^16.
    function automatic csa_t csa3(input prod_t x, input prod_t y, input prod_t z);
        csa_t r;
        r.s = x ^ y ^ z;
        r.c = ((x & y) | (x & z) | (y & z)) << 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dctm_mul8x8.sv
`default_nettype none
// ============================================================================
// Module      : dctm_mul8x8
// Description : Combinational unsigned 8x8->16 array multiplier built from
//               shifted partial products, a carry-save tree and a ripple adder.
// Revision    : 1.0 - initial release
// ============================================================================
module dctm_mul8x8
    import dctm_pkg::*;
(
    input  pix_t  i_a,
    input  coef_t i_b,
    output prod_t o_prod
);

    localparam int c_PW = 2 * PIX_W;

    prod_t w_pp [PIX_W];

    generate
        for (genvar i = 0; i < PIX_W; i++) begin : g_pp
            assign w_pp[i] = prod_t'({{PIX_W{1'b0}}, i_a & {PIX_W{i_b[i]}}} << i);
        end
    endgenerate

    csa_t  w_l1_0, w_l1_1, w_l2_0, w_l2_1, w_l3_0, w_l4_0;
    prod_t w_x, w_y;

    // 8 rows -> 6 -> 4 -> 3 -> 2 before the carry-propagate adder
    always_comb begin
        w_l1_0 = csa3(w_pp[0], w_pp[1], w_pp[2]);
        w_l1_1 = csa3(w_pp[3], w_pp[4], w_pp[5]);
        w_l2_0 = csa3(w_l1_0.s, w_l1_0.c, w_l1_1.s);
        w_l2_1 = csa3(w_l1_1.c, w_pp[6], w_pp[7]);
        w_l3_0 = csa3(w_l2_0.s, w_l2_0.c, w_l2_1.s);
        w_l4_0 = csa3(w_l3_0.s, w_l3_0.c, w_l2_1.c);
        w_x    = w_l4_0.s;
        w_y    = w_l4_0.c;
    end

    logic [c_PW-1:0] w_cy;
    logic [c_PW-1:0] w_sum;

    assign w_cy[0] = 1'b0;

    generate
        for (genvar i = 0; i < c_PW; i++) begin : g_rca
            assign w_sum[i] = w_x[i] ^ w_y[i] ^ w_cy[i];
            if (i < c_PW - 1) begin : g_cy
                assign w_cy[i+1] = (w_x[i] & w_y[i]) | (w_x[i] & w_cy[i]) | (w_y[i] & w_cy[i]);
            end
        end
    endgenerate

    assign o_prod = w_sum;

endmodule
`default_nettype wire

// File: rtl/dctm.sv
`default_nettype none
// ============================================================================
// Module      : dctm
// Description : Two-stage pixel x Q1.7 coefficient multiplier with
//               round-half-up and saturation to 8 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module dctm
    import dctm_pkg::*;
#(
    parameter int W    = 8,
    parameter int FRAC = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p
);

    localparam int c_PROD_W = 2 * W;
    localparam int c_Q_W    = c_PROD_W + 1 - FRAC;

    logic [W-1:0]        r_a_q, r_b_q, r_p_q;
    logic [W-1:0]        w_a_d, w_b_d, w_p_d;
    prod_t               w_prod;
    logic [c_PROD_W:0]   w_rnd;
    logic [c_Q_W-1:0]    w_q;

    dctm_mul8x8 u_mul (
        .i_a    (r_a_q),
        .i_b    (r_b_q),
        .o_prod (w_prod)
    );

    always_comb begin
        w_a_d = a;
        w_b_d = b;
        w_rnd = {1'b0, w_prod} + (c_PROD_W+1)'(ROUND_K);
        w_q   = w_rnd[c_PROD_W:FRAC];
        // Any set bit above the result width means the value exceeds SAT_MAX
        w_p_d = (|w_q[c_Q_W-1:W]) ? W'(SAT_MAX) : w_q[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_q <= '0;
            r_b_q <= '0;
            r_p_q <= '0;
        end else begin
            r_a_q <= w_a_d;
            r_b_q <= w_b_d;
            r_p_q <= w_p_d;
        end
    end

    assign p = r_p_q;

endmodule
`default_nettype wire

// File: tb/tb_dctm.sv
`default_nettype none
// ============================================================================
// Module      : tb_dctm
// Description : Scoreboard bench for dctm: directed vectors, resets, random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dctm;

    logic       clk;
    logic       rst;
    logic [7:0] a, b;
    logic [7:0] p;

    typedef struct {
        logic [7:0] v;
        int         due;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    dctm #(.W(8), .FRAC(7)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .p   (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops the entry due on this edge and compares.
    always @(posedge clk) begin
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed id=%0d due=%0d now=%0d", sb[0].id, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (p !== e.v) begin
                errors++;
                $display("FAIL stream id=%0d got=%0d exp=%0d", e.id, p, e.v);
            end
        end
    end

    function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y);
        int r;
        r = (int'(x) * int'(y) + 64) >>> 7;
        return (r > 255) ? 8'd255 : 8'(r);
    endfunction

    // Drive at negedge; sampled at the next posedge, visible one edge later.
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [7:0] ev, input int id);
        @(negedge clk);
        a = x;
        b = y;
        sb.push_back('{v: ev, due: cyc + 2, id: id});
    endtask

    task automatic check_now(input string nm, input logic [7:0] ev);
        checks++;
        if (p !== ev) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, p, ev);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] e;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst = 1'b1;
        a   = 8'd200;
        b   = 8'd200;

        // Reset held while clocking: output stays 0
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_now("rst_hold", 8'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{v: 8'd0,   due: cyc + 1, id: 900});
        sb.push_back('{v: 8'd255, due: cyc + 2, id: 901});
        @(negedge clk);

        // Zeros then unity: 200 must not appear on the first edge
        issue(8'd0, 8'd0, 8'd0, 1);
        issue(8'd0, 8'd0, 8'd0, 2);
        issue(8'd200, 8'd128, 8'd200, 3);
        for (int i = 1; i <= 10; i++)
            issue(8'(i), 8'd128, 8'(i), 10 + i);

        vecs = '{
            '{8'd100, 8'd64,  8'd50},
            '{8'd1,   8'd64,  8'd1},
            '{8'd3,   8'd1,   8'd0},
            '{8'd0,   8'd255, 8'd0},
            '{8'd255, 8'd255, 8'd255},
            '{8'd200, 8'd192, 8'd255},
            '{8'd170, 8'd192, 8'd255},
            '{8'd255, 8'd0,   8'd0},
            '{8'd1,   8'd63,  8'd0},
            '{8'd2,   8'd32,  8'd1},
            '{8'd127, 8'd1,   8'd1},
            '{8'd255, 8'd128, 8'd255},
            '{8'd129, 8'd255, 8'd255},
            '{8'd128, 8'd255, 8'd255},
            '{8'd64,  8'd255, 8'd128}
        };
        foreach (vecs[i])
            issue(vecs[i].a, vecs[i].b, vecs[i].e, 100 + i);

        // Mid-stream asynchronous reset between edges
        issue(8'd90, 8'd128, 8'd90, 200);
        issue(8'd91, 8'd128, 8'd91, 201);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_now("async_rst", 8'd0);
        sb.delete();
        @(negedge clk);
        check_now("rst_mid_hold", 8'd0);
        rst = 1'b0;
        a   = 8'd77;
        b   = 8'd128;
        sb.push_back('{v: 8'd0,  due: cyc + 1, id: 300});
        sb.push_back('{v: 8'd77, due: cyc + 2, id: 301});
        issue(8'd40, 8'd64, 8'd20, 302);

        for (int i = 0; i < 65536; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            issue(ra, rb, model(ra, rb), 1000 + i);
        end

        begin
            int budget;
            budget = 10;
            while (sb.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (sb.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain left=%0d exp=0", sb.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
